// File: rtl/llc_output_encoder_pkg.sv
// Shared widths, DMA serializer state and outbound message layouts for the LLC output encoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package llc_output_encoder_pkg;

    localparam int RSP_W          = 96;
    localparam int FWD_W          = 64;
    localparam int MEM_W          = 200;
    localparam int WORD_W         = 64;
    localparam int WORDS_PER_LINE = 2;
    localparam int DMA_HDR_W      = 32;
    localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);
    localparam int DMA_OUT_W      = DMA_HDR_W + WORD_W;
    localparam int STAT_W         = 16;

    typedef enum logic {IDLE, SEND} llc_dma_state_t;

    // Line viewed as an array of words; word 0 occupies the low bits.
    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] dma_line_t;

    typedef struct packed {
        logic [31:0]  hdr;
        logic [63:0]  line_word;
    } rsp_msg_t;

    typedef struct packed {
        logic [31:0]  hdr;
        logic [31:0]  addr;
    } fwd_msg_t;

    typedef struct packed {
        logic [31:0]  hdr;
        logic [39:0]  addr;
        logic [127:0] line;
    } mem_msg_t;

    typedef struct packed {
        logic [DMA_HDR_W-1:0] hdr;
        logic [WORD_W-1:0]    word;
    } dma_beat_t;

    // Event counter that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/llc_output_encoder_if.sv
// Bundle of the four LLC outbound valid/ready channels.
// Latency: n/a (wires only).
// Backpressure: each channel holds valid and data until its ready is seen.
interface llc_output_encoder_if;
    import llc_output_encoder_pkg::*;

    logic      llc_rsp_out_valid;
    logic      llc_rsp_out_ready;
    rsp_msg_t  llc_rsp_out_data;

    logic      llc_fwd_out_valid;
    logic      llc_fwd_out_ready;
    fwd_msg_t  llc_fwd_out_data;

    logic      llc_mem_req_valid;
    logic      llc_mem_req_ready;
    mem_msg_t  llc_mem_req_data;

    logic      llc_dma_rsp_out_valid;
    logic      llc_dma_rsp_out_ready;
    dma_beat_t llc_dma_rsp_out_data;
    logic      llc_dma_rsp_out_last;

    modport master (
        output llc_rsp_out_valid, llc_rsp_out_data,
        output llc_fwd_out_valid, llc_fwd_out_data,
        output llc_mem_req_valid, llc_mem_req_data,
        output llc_dma_rsp_out_valid, llc_dma_rsp_out_data, llc_dma_rsp_out_last,
        input  llc_rsp_out_ready, llc_fwd_out_ready, llc_mem_req_ready, llc_dma_rsp_out_ready
    );

    modport slave (
        input  llc_rsp_out_valid, llc_rsp_out_data,
        input  llc_fwd_out_valid, llc_fwd_out_data,
        input  llc_mem_req_valid, llc_mem_req_data,
        input  llc_dma_rsp_out_valid, llc_dma_rsp_out_data, llc_dma_rsp_out_last,
        output llc_rsp_out_ready, llc_fwd_out_ready, llc_mem_req_ready, llc_dma_rsp_out_ready
    );

endinterface

// File: rtl/llc_out_slot.sv
// One-entry outbound holding register with full bit, can_send and command-while-busy pulse.
// Latency: 1 cycle from send to valid.
// Backpressure: can_send drops only when full and ready is low; a send then is dropped and flagged.
module llc_out_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         send_i,
    input  logic [W-1:0] payload_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         can_send_o,
    output logic         err_o
);

    logic         full_q;
    logic [W-1:0] data_q;

    // Ready frees the slot this same cycle, so a send may overlap the outgoing handshake.
    assign can_send_o = !full_q || ready_i;
    assign err_o      = send_i && !can_send_o;
    assign valid_o    = full_q;
    assign data_o     = data_q;

    // Capture on accepted send (replacing a departing message), otherwise drain on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (send_i && can_send_o) begin
            full_q <= 1'b1;
            data_q <= payload_i;
        end else if (full_q && ready_i) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/llc_output_encoder.sv
// LLC transmit encoder: three single-entry message slots plus a DMA line-to-beat serializer.
// Latency: 1 cycle from send command to valid on every channel; DMA emits one word per handshake.
// Backpressure: valid/data held until ready; can_send_* gate the FSM; LLC_OUT_STATS_EN adds handshake counters.
module llc_output_encoder
    import llc_output_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send_rsp_i,
    input  logic                  send_fwd_i,
    input  logic                  send_mem_i,
    input  rsp_msg_t              rsp_payload_i,
    input  fwd_msg_t              fwd_payload_i,
    input  mem_msg_t              mem_payload_i,
    input  logic                  send_dma_rsp_i,
    input  logic [DMA_HDR_W-1:0]  dma_hdr_i,
    input  dma_line_t             dma_line_i,
    input  logic [WORD_IDX_W-1:0] dma_first_word_i,
    input  logic [WORD_IDX_W-1:0] dma_last_word_i,
    llc_output_encoder_if.master  out_if,
    output logic                  can_send_rsp_o,
    output logic                  can_send_fwd_o,
    output logic                  can_send_mem_o,
    output logic                  can_send_dma_o,
    output logic                  out_idle_o,
    output logic                  proto_err_o
`ifdef LLC_OUT_STATS_EN
   ,output logic [STAT_W-1:0]     stat_rsp_cnt_o,
    output logic [STAT_W-1:0]     stat_fwd_cnt_o,
    output logic [STAT_W-1:0]     stat_mem_cnt_o,
    output logic [STAT_W-1:0]     stat_dma_cnt_o
`endif
);

    logic rsp_err, fwd_err, mem_err, dma_err;

    llc_out_slot #(.W(RSP_W)) u_rsp_slot (
        .clk(clk), .rst(rst), .send_i(send_rsp_i), .payload_i(rsp_payload_i),
        .ready_i(out_if.llc_rsp_out_ready), .valid_o(out_if.llc_rsp_out_valid),
        .data_o(out_if.llc_rsp_out_data), .can_send_o(can_send_rsp_o), .err_o(rsp_err)
    );

    llc_out_slot #(.W(FWD_W)) u_fwd_slot (
        .clk(clk), .rst(rst), .send_i(send_fwd_i), .payload_i(fwd_payload_i),
        .ready_i(out_if.llc_fwd_out_ready), .valid_o(out_if.llc_fwd_out_valid),
        .data_o(out_if.llc_fwd_out_data), .can_send_o(can_send_fwd_o), .err_o(fwd_err)
    );

    llc_out_slot #(.W(MEM_W)) u_mem_slot (
        .clk(clk), .rst(rst), .send_i(send_mem_i), .payload_i(mem_payload_i),
        .ready_i(out_if.llc_mem_req_ready), .valid_o(out_if.llc_mem_req_valid),
        .data_o(out_if.llc_mem_req_data), .can_send_o(can_send_mem_o), .err_o(mem_err)
    );

    llc_dma_state_t          state_q, state_d;
    logic [WORD_IDX_W-1:0]   cnt_q, cnt_d;
    logic [WORD_IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [DMA_HDR_W-1:0]    hdr_q, hdr_d;
    dma_line_t               line_q, line_d;
    logic                    dma_line_done;
    logic                    proto_err_q;

    // DMA serializer state; everything restarts empty on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_idx_q <= '0;
            hdr_q      <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            hdr_q      <= hdr_d;
            line_q     <= line_d;
        end
    end

    // DMA next state and beat outputs; an inverted range collapses to one beat of the first word.
    always_comb begin
        state_d                      = state_q;
        cnt_d                        = cnt_q;
        last_idx_d                   = last_idx_q;
        hdr_d                        = hdr_q;
        line_d                       = line_q;
        can_send_dma_o               = 1'b0;
        dma_err                      = 1'b0;
        dma_line_done                = 1'b0;
        out_if.llc_dma_rsp_out_valid = 1'b0;
        out_if.llc_dma_rsp_out_data  = '0;
        out_if.llc_dma_rsp_out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                can_send_dma_o = 1'b1;
                if (send_dma_rsp_i) begin
                    state_d    = SEND;
                    hdr_d      = dma_hdr_i;
                    line_d     = dma_line_i;
                    cnt_d      = dma_first_word_i;
                    last_idx_d = (dma_last_word_i < dma_first_word_i) ? dma_first_word_i
                                                                      : dma_last_word_i;
                end
            end
            SEND: begin
                dma_err                          = send_dma_rsp_i;
                out_if.llc_dma_rsp_out_valid     = 1'b1;
                out_if.llc_dma_rsp_out_data.hdr  = hdr_q;
                out_if.llc_dma_rsp_out_data.word = line_q[cnt_q];
                out_if.llc_dma_rsp_out_last      = (cnt_q == last_idx_q);
                if (out_if.llc_dma_rsp_out_ready) begin
                    if (cnt_q == last_idx_q) begin
                        state_d       = IDLE;
                        dma_line_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flag for any command issued while its channel could not take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (rsp_err || fwd_err || mem_err || dma_err) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err_o = proto_err_q;
    assign out_idle_o  = !out_if.llc_rsp_out_valid && !out_if.llc_fwd_out_valid &&
                         !out_if.llc_mem_req_valid && (state_q == IDLE);

`ifdef LLC_OUT_STATS_EN
    logic [STAT_W-1:0] rsp_cnt_q, fwd_cnt_q, mem_cnt_q, dma_cnt_q;

    // Completed-handshake counters; DMA counts whole lines at their final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_cnt_q <= '0;
            fwd_cnt_q <= '0;
            mem_cnt_q <= '0;
            dma_cnt_q <= '0;
        end else begin
            if (out_if.llc_rsp_out_valid && out_if.llc_rsp_out_ready) rsp_cnt_q <= sat_inc(rsp_cnt_q);
            if (out_if.llc_fwd_out_valid && out_if.llc_fwd_out_ready) fwd_cnt_q <= sat_inc(fwd_cnt_q);
            if (out_if.llc_mem_req_valid && out_if.llc_mem_req_ready) mem_cnt_q <= sat_inc(mem_cnt_q);
            if (dma_line_done)                                        dma_cnt_q <= sat_inc(dma_cnt_q);
        end
    end

    assign stat_rsp_cnt_o = rsp_cnt_q;
    assign stat_fwd_cnt_o = fwd_cnt_q;
    assign stat_mem_cnt_o = mem_cnt_q;
    assign stat_dma_cnt_o = dma_cnt_q;
`endif

endmodule

// File: tb/tb_llc_output_encoder.sv
// Directed bench for llc_output_encoder: vector table for the message slots, hand sequences for DMA and reset.
// Latency: checks sample #1 after the rising edge; can_send is sampled before the edge.
// Backpressure: ready patterns are part of every vector.
module tb_llc_output_encoder;
    import llc_output_encoder_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  send_rsp, send_fwd, send_mem, send_dma_rsp;
    logic [RSP_W-1:0]      rsp_payload;
    logic [FWD_W-1:0]      fwd_payload;
    logic [MEM_W-1:0]      mem_payload;
    logic [DMA_HDR_W-1:0]  dma_hdr;
    logic [WORDS_PER_LINE*WORD_W-1:0] dma_line;
    logic [WORD_IDX_W-1:0] dma_first_word, dma_last_word;
    logic                  can_send_rsp, can_send_fwd, can_send_mem, can_send_dma;
    logic                  out_idle, proto_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    llc_output_encoder_if bus ();

    llc_output_encoder dut (
        .clk(clk), .rst(rst),
        .send_rsp_i(send_rsp), .send_fwd_i(send_fwd), .send_mem_i(send_mem),
        .rsp_payload_i(rsp_payload), .fwd_payload_i(fwd_payload), .mem_payload_i(mem_payload),
        .send_dma_rsp_i(send_dma_rsp), .dma_hdr_i(dma_hdr), .dma_line_i(dma_line),
        .dma_first_word_i(dma_first_word), .dma_last_word_i(dma_last_word),
        .out_if(bus.master),
        .can_send_rsp_o(can_send_rsp), .can_send_fwd_o(can_send_fwd),
        .can_send_mem_o(can_send_mem), .can_send_dma_o(can_send_dma),
        .out_idle_o(out_idle), .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] snd;      // {mem, fwd, rsp}
        logic [7:0] rsp_pl, fwd_pl, mem_pl;
        logic [2:0] rdy;      // {mem, fwd, rsp}
        logic [2:0] exp_cs;   // can_send before the edge
        logic [2:0] exp_vld;  // valids after the edge
        logic [7:0] exp_rsp, exp_fwd, exp_mem;
        logic       exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [3:0] r);  // {dma, mem, fwd, rsp}
        bus.llc_rsp_out_ready     = r[0];
        bus.llc_fwd_out_ready     = r[1];
        bus.llc_mem_req_ready     = r[2];
        bus.llc_dma_rsp_out_ready = r[3];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] valids();
        return {bus.llc_dma_rsp_out_valid, bus.llc_mem_req_valid,
                bus.llc_fwd_out_valid, bus.llc_rsp_out_valid};
    endfunction

    initial begin
        rst = 1'b1;
        {send_rsp, send_fwd, send_mem, send_dma_rsp} = '0;
        rsp_payload = '0; fwd_payload = '0; mem_payload = '0;
        dma_hdr = '0; dma_line = '0; dma_first_word = '0; dma_last_word = '0;
        set_ready(4'b0000);

        //           snd     rsp    fwd    mem    rdy     cs      vld     e_rsp  e_fwd  e_mem err
        tbl[0]  = '{3'b010, 8'h00, 8'hA5, 8'h00, 3'b111, 3'b111, 3'b010, 8'h00, 8'hA5, 8'h00, 1'b0};
        tbl[1]  = '{3'b000, 8'h00, 8'h00, 8'h00, 3'b111, 3'b111, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{3'b001, 8'h11, 8'h00, 8'h00, 3'b000, 3'b111, 3'b001, 8'h11, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b110, 3'b001, 8'h11, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{3'b001, 8'h22, 8'h00, 8'h00, 3'b000, 3'b110, 3'b001, 8'h11, 8'h00, 8'h00, 1'b1};
        tbl[5]  = '{3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b110, 3'b001, 8'h11, 8'h00, 8'h00, 1'b1};
        tbl[6]  = '{3'b000, 8'h00, 8'h00, 8'h00, 3'b001, 3'b111, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[7]  = '{3'b100, 8'h00, 8'h00, 8'h01, 3'b000, 3'b111, 3'b100, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[8]  = '{3'b100, 8'h00, 8'h00, 8'h02, 3'b100, 3'b111, 3'b100, 8'h00, 8'h00, 8'h02, 1'b1};
        tbl[9]  = '{3'b000, 8'h00, 8'h00, 8'h00, 3'b100, 3'b111, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[10] = '{3'b111, 8'h33, 8'h44, 8'h55, 3'b000, 3'b111, 3'b111, 8'h33, 8'h44, 8'h55, 1'b1};
        tbl[11] = '{3'b000, 8'h00, 8'h00, 8'h00, 3'b111, 3'b111, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1};

        // Reset state
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_valids", 256'(valids()), 256'(4'b0000));
        chk("rst_rsp_data", 256'(bus.llc_rsp_out_data), 256'(0));
        chk("rst_mem_data", 256'(bus.llc_mem_req_data), 256'(0));
        chk("rst_dma_data", 256'(bus.llc_dma_rsp_out_data), 256'(0));
        chk("rst_dma_last", 256'(bus.llc_dma_rsp_out_last), 256'(0));
        chk("rst_can_send", 256'({can_send_dma, can_send_mem, can_send_fwd, can_send_rsp}), 256'(4'b1111));
        chk("rst_idle", 256'(out_idle), 256'(1));
        chk("rst_err", 256'(proto_err), 256'(0));

        // Message slot vectors
        for (int i = 0; i < 12; i++) begin
            {send_mem, send_fwd, send_rsp} = tbl[i].snd;
            rsp_payload = RSP_W'(tbl[i].rsp_pl);
            fwd_payload = FWD_W'(tbl[i].fwd_pl);
            mem_payload = MEM_W'(tbl[i].mem_pl);
            set_ready({1'b0, tbl[i].rdy});
            #1;
            chk($sformatf("v%0d_can_send", i),
                256'({can_send_mem, can_send_fwd, can_send_rsp}), 256'(tbl[i].exp_cs));
            step();
            {send_mem, send_fwd, send_rsp} = 3'b000;
            chk($sformatf("v%0d_valid", i), 256'(valids()), 256'({1'b0, tbl[i].exp_vld}));
            if (tbl[i].exp_vld[0]) chk($sformatf("v%0d_rsp_data", i), 256'(bus.llc_rsp_out_data), 256'(tbl[i].exp_rsp));
            if (tbl[i].exp_vld[1]) chk($sformatf("v%0d_fwd_data", i), 256'(bus.llc_fwd_out_data), 256'(tbl[i].exp_fwd));
            if (tbl[i].exp_vld[2]) chk($sformatf("v%0d_mem_data", i), 256'(bus.llc_mem_req_data), 256'(tbl[i].exp_mem));
            chk($sformatf("v%0d_err", i), 256'(proto_err), 256'(tbl[i].exp_err));
            chk($sformatf("v%0d_idle", i), 256'(out_idle), 256'(tbl[i].exp_vld == 3'b000));
        end

        // DMA two-beat line with toggling ready
        set_ready(4'b0000);
        dma_hdr = 32'h1234_5678;
        dma_line = {64'hBB, 64'hAA};
        dma_first_word = 1'b0; dma_last_word = 1'b1;
        send_dma_rsp = 1'b1;
        #1;
        chk("dma_can_send_idle", 256'(can_send_dma), 256'(1));
        step();
        send_dma_rsp = 1'b0;
        chk("dma_b0_valid", 256'(bus.llc_dma_rsp_out_valid), 256'(1));
        chk("dma_b0_data", 256'(bus.llc_dma_rsp_out_data), 256'({32'h1234_5678, 64'hAA}));
        chk("dma_b0_last", 256'(bus.llc_dma_rsp_out_last), 256'(0));
        chk("dma_busy_can_send", 256'(can_send_dma), 256'(0));
        chk("dma_busy_idle", 256'(out_idle), 256'(0));
        step();
        chk("dma_b0_hold", 256'(bus.llc_dma_rsp_out_data), 256'({32'h1234_5678, 64'hAA}));
        set_ready(4'b1000);
        step();
        set_ready(4'b0000);
        chk("dma_b1_data", 256'(bus.llc_dma_rsp_out_data), 256'({32'h1234_5678, 64'hBB}));
        chk("dma_b1_last", 256'(bus.llc_dma_rsp_out_last), 256'(1));
        step();
        chk("dma_b1_hold", 256'(bus.llc_dma_rsp_out_valid), 256'(1));
        set_ready(4'b1000);
        step();
        set_ready(4'b0000);
        chk("dma_done_valid", 256'(bus.llc_dma_rsp_out_valid), 256'(0));
        chk("dma_done_idle", 256'(out_idle), 256'(1));
        chk("dma_done_can_send", 256'(can_send_dma), 256'(1));

        // Single-beat line; a second start mid-beat is dropped and flagged
        do_reset();
        #1;
        chk("rst2_err", 256'(proto_err), 256'(0));
        dma_first_word = 1'b1; dma_last_word = 1'b1;
        send_dma_rsp = 1'b1;
        step();
        dma_line = {64'hDD, 64'hCC};
        chk("dma1_data", 256'(bus.llc_dma_rsp_out_data), 256'({32'h1234_5678, 64'hBB}));
        chk("dma1_last", 256'(bus.llc_dma_rsp_out_last), 256'(1));
        step();
        send_dma_rsp = 1'b0;
        chk("dma1_busy_err", 256'(proto_err), 256'(1));
        chk("dma1_busy_data", 256'(bus.llc_dma_rsp_out_data), 256'({32'h1234_5678, 64'hBB}));
        set_ready(4'b1000);
        step();
        chk("dma1_done_valid", 256'(bus.llc_dma_rsp_out_valid), 256'(0));

        // Inverted range: one beat of the first word
        set_ready(4'b0000);
        dma_line = {64'hBB, 64'hAA};
        dma_first_word = 1'b1; dma_last_word = 1'b0;
        send_dma_rsp = 1'b1;
        step();
        send_dma_rsp = 1'b0;
        chk("dmainv_data", 256'(bus.llc_dma_rsp_out_data), 256'({32'h1234_5678, 64'hBB}));
        chk("dmainv_last", 256'(bus.llc_dma_rsp_out_last), 256'(1));
        set_ready(4'b1000);
        step();
        set_ready(4'b0000);
        chk("dmainv_done", 256'(bus.llc_dma_rsp_out_valid), 256'(0));

        // Reset with rsp held and DMA mid-line
        send_rsp = 1'b1; rsp_payload = RSP_W'(8'h77);
        dma_first_word = 1'b0; dma_last_word = 1'b1;
        send_dma_rsp = 1'b1;
        step();
        send_rsp = 1'b0; send_dma_rsp = 1'b0;
        chk("pre_rst_valids", 256'(valids()), 256'(4'b1001));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valids", 256'(valids()), 256'(4'b0000));
        chk("mid_rst_idle", 256'(out_idle), 256'(1));
        chk("mid_rst_err", 256'(proto_err), 256'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/llc_output_encoder.md
Name: llc_output_encoder

Overview:
- Transmit-side counterpart of the LLC input decoder.
- Accepts one-cycle send commands plus payloads from the LLC control FSM, and holds each message in a per-channel output register.
- Drives valid/ready handshakes on the four LLC outbound channels: rsp_out, fwd_out, mem_req and dma_rsp_out.
- Serializes DMA line responses into word beats, and reports per-channel readiness and global idle back to the FSM.

Parameters:
- RSP_W, 96, rsp_out message width (header+line)
- FWD_W, 64, fwd_out message width
- MEM_W, 200, mem_req message width
- WORD_W, 64, DMA data word width
- WORDS_PER_LINE, 2, words per cache line (power of 2, >=2)
- DMA_HDR_W, 32, DMA response header width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- send_rsp / send_fwd / send_mem  in  1 each  one-cycle send commands
- rsp_payload  in  RSP_W; fwd_payload  in  FWD_W; mem_payload  in  MEM_W
- send_dma_rsp  in  1  start DMA line response
- dma_hdr  in  DMA_HDR_W  DMA response header
- dma_line  in  WORDS_PER_LINE*WORD_W  DMA line data
- dma_first_word, dma_last_word  in  $clog2(WORDS_PER_LINE)  inclusive word range
- llc_rsp_out_ready / llc_fwd_out_ready / llc_mem_req_ready / llc_dma_rsp_out_ready  in  1 each
- llc_rsp_out_valid / llc_fwd_out_valid / llc_mem_req_valid / llc_dma_rsp_out_valid  out  1 each
- llc_rsp_out_data  out  RSP_W; llc_fwd_out_data  out  FWD_W; llc_mem_req_data  out  MEM_W
- llc_dma_rsp_out_data  out  DMA_HDR_W+WORD_W  {hdr, word}
- llc_dma_rsp_out_last  out  1  final beat of the line
- can_send_rsp / can_send_fwd / can_send_mem / can_send_dma  out  1 each
- out_idle  out  1  all channels empty and DMA FSM in IDLE
- proto_err  out  1  sticky command-while-busy flag

Behaviour:
- Reset (sync, rst=1 at posedge): all valids=0, all data=0, last=0, DMA FSM=IDLE, beat counter=0, proto_err=0, can_send_*=1, out_idle=1.
- rsp/fwd/mem channels each have a 1-entry holding register with a full bit.
  - can_send_X = !full_X | llc_X_ready (combinational, so back-to-back sends at full throughput).
  - send_X with can_send_X: payload is captured and full set next cycle. Latency from command to valid is 1 cycle.
  - Valid handshake complete (valid & ready) with no new send: full clears.
  - Handshake and send in the same cycle: the new payload replaces the old one and full stays 1.
  - send_X while !can_send_X: the command is dropped, the register is unchanged, and proto_err is set.
- llc_X_valid = full_X. Data is stable while valid & !ready.
- DMA FSM states: IDLE, SEND.
  - IDLE: can_send_dma=1. On send_dma_rsp, latch hdr, line, first and last word; set cnt=first; go to SEND. Valid rises the next cycle.
  - SEND: valid=1, data={hdr, line word[cnt]}, last=(cnt==last_word).
    - On handshake with !last: cnt+1.
    - On handshake with last: go to IDLE. can_send_dma=0 throughout SEND.
  - first>last is treated as a single beat of word first with last=1.
  - send_dma_rsp while in SEND: dropped, proto_err set.
- Channels are independent; no cross-channel ordering is imposed. The FSM enforces ordering via can_send_*.
- out_idle = !full_rsp & !full_fwd & !full_mem & (dma_state==IDLE). It is used by the FSM before reporting flush/reset done.
- Reset mid-operation: all pending messages are discarded and valids drop the cycle after rst is sampled.

Optional Feature:
- LLC_OUT_STATS_EN defined adds:
  - 16-bit saturating counters of completed handshakes per channel (DMA counts lines, not beats).
  - Outputs stat_rsp_cnt, stat_fwd_cnt, stat_mem_cnt, stat_dma_cnt, cleared by rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- cache_consts.svh: word/line widths, WORDS_PER_LINE.
- cache_types.svh: llc_dma_state_t enum {IDLE, SEND}, and the message structs whose widths equal RSP_W/FWD_W/MEM_W.
- One sub-module, llc_out_slot, parameterized by width: holding register, full bit, can_send and proto_err pulse. It is instantiated three times. The DMA serializer stays inline.

Test Plan:
- send_fwd payload 0xA5 with ready=1 → valid=1 next cycle, data=0xA5, cleared after 1 cycle; can_send_fwd stays 1.
- send_rsp with ready=0 for 3 cycles → valid held, data stable, can_send_rsp=0. A second send_rsp in that window → proto_err=1 and data unchanged.
- With full_mem=1 and ready=1, send_mem payload 0x2 in the same cycle → old payload consumed, next cycle valid=1 with data 0x2.
- DMA, WORDS_PER_LINE=2, first=0, last=1, line={0xBB,0xAA}, ready toggling → beats 0xAA (last=0) then 0xBB (last=1), then IDLE; out_idle=1 after the final handshake.
- DMA first=1, last=1 → exactly one beat 0xBB with last=1; send_dma_rsp during the beat → proto_err=1.
- rst asserted while rsp full and DMA in SEND → next cycle all valids=0, out_idle=1, proto_err=0.
